// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter with a small TX FIFO.
// Sits on the data-RAM bus (Address/WriteData/MemWrite/MemRead), exposes
// TXDATA / STATUS / BAUDDIV registers in a 16-byte window and serializes
// queued bytes on TxD as 8N1 frames.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit between the
// last data bit and the stop bit (8E1) and sets STATUS bit 9.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR      = 32'h1001_0400,
   parameter int          FIFO_DEPTH     = 4,
   parameter logic [15:0] BAUD_DIV_RESET = 16'd434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   output logic [31:0] ReadData,
   output logic        Selected,
   output logic        TxD,
   output logic        TxBusy
);

   localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [4:0]  DEPTH_C  = 5'(FIFO_DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
`ifdef UART_TX_PARITY_EN
   localparam logic        PARITY_EN = 1'b1;
`else
   localparam logic        PARITY_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd4,
`endif
      S_STOP   = 3'd3
   } state_t;

   // Even parity of a data byte: the bit that makes the total count of ones even.
   function automatic logic f_even_parity(input logic [7:0] d);
      return ^d;
   endfunction

   // FIFO storage and control registers
   logic [7:0]    r_mem [0:FIFO_DEPTH-1];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [4:0]    r_count;
   logic          r_ovf;
   logic [15:0]   r_baud;

   // Transmitter registers
   state_t        r_state;
   logic [15:0]   r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic [15:0]   r_period;
   logic          r_txd;
   logic          r_busy;

   // Decode and next-state wires
   logic          w_sel;
   logic [1:0]    w_off;
   logic          w_push_req;
   logic          w_baud_wr;
   logic          w_status_rd;
   logic          w_full;
   logic          w_empty;
   logic          w_pop;
   logic          w_push_ok;
   logic          w_ovf_set;
   logic [4:0]    w_count_n;
   logic [31:0]   w_status;
   state_t        w_state_n;
   logic [15:0]   w_cnt_n;
   logic [2:0]    w_bit_n;
   logic [7:0]    w_shift_n;
   logic [15:0]   w_period_n;
   logic          w_txd_n;
   logic          w_busy_n;
   logic          w_unused_bits;

   assign w_sel       = (Address[31:4] == BASE_ADDR[31:4]);
   assign w_off       = Address[3:2];
   assign w_push_req  = w_sel & MemWrite & (w_off == 2'd0);
   assign w_baud_wr   = w_sel & MemWrite & (w_off == 2'd2);
   assign w_status_rd = w_sel & MemRead  & (w_off == 2'd1);
   assign w_full      = (r_count == DEPTH_C);
   assign w_empty     = (r_count == 5'd0);
   // A full FIFO still accepts a push when the transmitter pops on the same edge.
   assign w_push_ok   = w_push_req & (~w_full | w_pop);
   assign w_ovf_set   = w_push_req & w_full & ~w_pop;

   assign w_status = {22'd0, PARITY_EN, r_count, r_ovf,
                      (r_state != S_IDLE), w_empty, w_full};

   assign Selected = w_sel;
   assign TxD      = r_txd;
   assign TxBusy   = r_busy;

   // Address bits below word granularity and upper store bits carry no meaning here.
   assign w_unused_bits = ^{Address[1:0], WriteData[31:16]};

   // Load-mux read data: zero unless this window is selected by a load.
   always_comb begin
      ReadData = 32'd0;
      if (w_sel && MemRead) begin
         case (w_off)
            2'd1:    ReadData = w_status;
            2'd2:    ReadData = {16'd0, r_baud};
            default: ReadData = 32'd0;
         endcase
      end else begin
         ReadData = 32'd0;
      end
   end

   // FIFO occupancy after this edge's push/pop.
   always_comb begin
      w_count_n = r_count;
      case ({w_push_ok, w_pop})
         2'b10:   w_count_n = r_count + 5'd1;
         2'b01:   w_count_n = r_count - 5'd1;
         default: w_count_n = r_count;
      endcase
   end

   // Transmit FSM next state: frame sequencing, bit timing and FIFO pop.
   always_comb begin
      w_state_n  = r_state;
      w_cnt_n    = r_cnt;
      w_bit_n    = r_bit;
      w_shift_n  = r_shift;
      w_period_n = r_period;
      w_pop      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop      = 1'b1;
               w_shift_n  = r_mem[r_rd_ptr];
               w_period_n = r_baud;
               w_cnt_n    = r_baud - 16'd1;
               w_state_n  = S_START;
            end else begin
               w_state_n  = S_IDLE;
            end
         end
         S_START: begin
            if (r_cnt == 16'd0) begin
               w_cnt_n   = r_period - 16'd1;
               w_bit_n   = 3'd0;
               w_state_n = S_DATA;
            end else begin
               w_cnt_n   = r_cnt - 16'd1;
            end
         end
         S_DATA: begin
            if (r_cnt == 16'd0) begin
               w_cnt_n = r_period - 16'd1;
               if (r_bit == 3'd7) begin
                  w_bit_n   = 3'd0;
`ifdef UART_TX_PARITY_EN
                  w_state_n = S_PARITY;
`else
                  w_state_n = S_STOP;
`endif
               end else begin
                  w_bit_n   = r_bit + 3'd1;
               end
            end else begin
               w_cnt_n = r_cnt - 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (r_cnt == 16'd0) begin
               w_cnt_n   = r_period - 16'd1;
               w_state_n = S_STOP;
            end else begin
               w_cnt_n   = r_cnt - 16'd1;
            end
         end
`endif
         S_STOP: begin
            if (r_cnt == 16'd0) begin
               if (!w_empty) begin
                  // Back-to-back: next start bit follows the stop bit with no gap.
                  w_pop      = 1'b1;
                  w_shift_n  = r_mem[r_rd_ptr];
                  w_period_n = r_baud;
                  w_cnt_n    = r_baud - 16'd1;
                  w_state_n  = S_START;
               end else begin
                  w_cnt_n    = 16'd0;
                  w_state_n  = S_IDLE;
               end
            end else begin
               w_cnt_n = r_cnt - 16'd1;
            end
         end
         default: begin
            w_state_n = S_IDLE;
         end
      endcase
   end

   // Line level and busy flag for the state being entered, so both are registered.
   always_comb begin
      w_txd_n = 1'b1;
      case (w_state_n)
         S_START:  w_txd_n = 1'b0;
         S_DATA:   w_txd_n = w_shift_n[w_bit_n];
`ifdef UART_TX_PARITY_EN
         S_PARITY: w_txd_n = f_even_parity(w_shift_n);
`endif
         default:  w_txd_n = 1'b1;
      endcase
      w_busy_n = (w_state_n != S_IDLE) | (w_count_n != 5'd0);
   end

   // FIFO byte storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= WriteData[7:0];
      end
   end

   // FIFO pointers, occupancy, sticky overflow and the BAUDDIV register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= 5'd0;
         r_ovf    <= 1'b0;
         r_baud   <= BAUD_DIV_RESET;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         r_count <= w_count_n;
         if (w_ovf_set) begin
            r_ovf <= 1'b1;
         end else if (w_status_rd) begin
            r_ovf <= 1'b0;
         end
         if (w_baud_wr) begin
            // A zero divider would stall the bit timer; treat it as one clock.
            r_baud <= (WriteData[15:0] == 16'd0) ? 16'd1 : WriteData[15:0];
         end
      end
   end

   // Transmit FSM state, bit timer and registered line outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= 16'd0;
         r_bit    <= 3'd0;
         r_shift  <= 8'd0;
         r_period <= BAUD_DIV_RESET;
         r_txd    <= 1'b1;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_cnt    <= w_cnt_n;
         r_bit    <= w_bit_n;
         r_shift  <= w_shift_n;
         r_period <= w_period_n;
         r_txd    <= w_txd_n;
         r_busy   <= w_busy_n;
      end
   end

endmodule
